// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB master slice
package apb_pkg;

    // Transfer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Peripheral window and completer slots
    localparam logic [31:0] APB_BASE      = 32'h1000_0000;
    localparam int          APB_SLOT_BITS = 12;
    localparam int          APB_NSLV      = 4;
    localparam int          APB_IDX_W     = 2;

    // Width of the ACCESS-phase wait counter
    localparam int          APB_TMO_W     = 8;

endpackage

// File: rtl/apb_addr_decode.sv
// rtl/apb_addr_decode.sv - combinational window decode to completer index and one-hot select
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int          NSLV = APB_NSLV,
    parameter logic [31:0] BASE = APB_BASE
) (
    input  logic [31:0]          addr_i,
    output logic                 hit_o,
    output logic [APB_IDX_W-1:0] idx_o,
    output logic [NSLV-1:0]      sel_o
);

    // Bits above the slot index must match the window base
    localparam int WIN_LSB = APB_SLOT_BITS + APB_IDX_W;

    // Slot index from the address, hit only inside the window and below NSLV
    always_comb begin
        idx_o = addr_i[WIN_LSB-1:APB_SLOT_BITS];
        hit_o = (addr_i[31:WIN_LSB] == BASE[31:WIN_LSB]) && (int'(idx_o) < NSLV);
        sel_o = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (hit_o && (int'(idx_o) == i)) begin
                sel_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB requester with decode, wait states and timeout
module apb_master
    import apb_pkg::*;
#(
    parameter int          NSLV    = APB_NSLV,
    parameter logic [31:0] BASE    = APB_BASE,
    parameter int          TIMEOUT = 255
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [31:0]            req_addr,
    input  logic                   req_write,
    input  logic [31:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [31:0]            PADDR,
    output logic [31:0]            PWDATA,
    output logic                   PWRITE,
    output logic                   PENABLE,
    output logic [NSLV-1:0]        PSEL,
    input  logic [NSLV-1:0][31:0]  PRDATA_s,
    input  logic [NSLV-1:0]        PREADY_s
);

    // Last ACCESS cycle that may still wait on PREADY before aborting
    localparam logic [APB_TMO_W-1:0] TMO_LAST = APB_TMO_W'(TIMEOUT - 1);

    apb_state_e           state_q;
    logic                 req_ready_q;
    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic [31:0]          rsp_rdata_q;
    logic [31:0]          paddr_q;
    logic [31:0]          pwdata_q;
    logic                 pwrite_q;
    logic                 penable_q;
    logic [NSLV-1:0]      psel_q;
    logic [APB_IDX_W-1:0] idx_q;
    logic [APB_TMO_W-1:0] cnt_q;

    logic                 dec_hit;
    logic [APB_IDX_W-1:0] dec_idx;
    logic [NSLV-1:0]      dec_sel;

    apb_addr_decode #(
        .NSLV (NSLV),
        .BASE (BASE)
    ) u_decode (
        .addr_i (req_addr),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx),
        .sel_o  (dec_sel)
    );

    // Transfer FSM with every bus and response output held in a register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            penable_q   <= 1'b0;
            psel_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        if (dec_hit) begin
                            // Bus fields only move on a real transfer so misses leave APB quiet
                            state_q  <= ST_SETUP;
                            psel_q   <= dec_sel;
                            idx_q    <= dec_idx;
                            paddr_q  <= req_addr;
                            pwrite_q <= req_write;
                            pwdata_q <= req_wdata;
                        end else begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end
                ST_ACCESS: begin
                    if (PREADY_s[idx_q]) begin
                        state_q     <= ST_RESP;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= pwrite_q ? 32'h0 : PRDATA_s[idx_q];
                    end else if (cnt_q == TMO_LAST) begin
                        // Completer never answered: abandon the transfer
                        state_q     <= ST_RESP;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    psel_q      <= '0;
                    penable_q   <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PENABLE   = penable_q;
    assign PSEL      = psel_q;

endmodule
